alu_engine: RTL and testbench
=============================

ALU_ENGINE -- requirements
Module: alu_engine

Interface
REQ-001 Parameters SHALL be:
- BUS_W, default 16, data_in/data_out width (16..32).
- AMM_ADDR_W, default 8, register-file address width.
- AMM_DATA_W, default 8, register-file data width (<= BUS_W-1).
- MAX_OPS, default 8, maximum operand count per command (1..15).
REQ-002 Ports SHALL be:
- clk  in  1  clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  BUS_W  command/operand word.
- valid_in  in  1  data_in qualifier.
- cmd_in  in  1  1 = header word, 0 = operand word.
- data_out  out  BUS_W  reply word.
- valid_out  out  1  data_out qualifier.
- cmd_out  out  1  1 = reply header, 0 = result word.
- amm_read  out  1  register-file read request.
- amm_address  out  AMM_ADDR_W  read address.
- amm_readdata  in  AMM_DATA_W  read data.
- amm_waitrequest  in  1  slave stall.
- amm_response  in  2  00 = OKAY, other = error.

Function
REQ-003 Header (valid_in=1, cmd_in=1) SHALL carry opcode = data_in[BUS_W-1:BUS_W-4] and count N = data_in[3:0].
REQ-004 Operand (valid_in=1, cmd_in=0) SHALL be:
- an immediate data_in[AMM_DATA_W-1:0] when data_in[BUS_W-1]=0;
- a register address data_in[AMM_ADDR_W-1:0] when data_in[BUS_W-1]=1.
REQ-005 States SHALL be IDLE, COLLECT, FETCH, EXEC, REPLY_HDR, REPLY_DATA.
- IDLE->COLLECT on header.
- COLLECT->FETCH after operand N is accepted.
- FETCH->EXEC when all register operands are resolved.
- EXEC->REPLY_HDR->REPLY_DATA->IDLE, one cycle each.
REQ-006 In IDLE, operand words SHALL be ignored; in FETCH, EXEC and REPLY states, all input words SHALL be ignored (no backpressure).
REQ-007 A header received in COLLECT SHALL discard the partial command and restart COLLECT with the new opcode and N.
REQ-008 FETCH SHALL issue reads in operand order, one outstanding at a time:
- amm_read=1 and amm_address held stable while amm_waitrequest=1;
- amm_readdata and amm_response are sampled in the cycle amm_read=1 and amm_waitrequest=0;
- amm_read drops for at least one cycle between reads.
REQ-009 Immediate operands SHALL consume no FETCH cycles; an all-immediate command SHALL spend exactly one cycle in FETCH.
REQ-010 Operands SHALL be zero-extended to BUS_W; all results SHALL be modulo 2^BUS_W.
REQ-011 Opcodes SHALL be:
- 0 ADD sum; 1 AND; 2 OR; 3 XOR; 4 NOT (N=1).
- 5 INC op+1 (N=1); 6 DEC op-1 (N=1, 0 wraps to all-ones).
- 7 MUL product truncated to BUS_W; 8..15 illegal.
REQ-012 A command SHALL be erroneous if:
- N=0, N>MAX_OPS, the opcode is illegal, or a unary opcode has N!=1 (erroneous N/opcode still runs COLLECT with N taken as 1 when N=0, clipped to MAX_OPS);
- or a fetch returns amm_response!=00 (ALU_ENGINE_ERR_EN only).
REQ-013 REPLY_HDR SHALL drive valid_out=1, cmd_out=1, data_out = {opcode, error bit at BUS_W-5, zeros, N at [3:0]}.
REQ-014 REPLY_DATA SHALL drive valid_out=1, cmd_out=0, data_out = result, or all-ones on error.
REQ-015 Outside the reply states, valid_out, cmd_out and data_out SHALL be 0; amm_read SHALL be 0 outside FETCH.
REQ-016 Latency SHALL be 4 cycles from acceptance of the last operand of an all-immediate command to the REPLY_DATA cycle.

Reset
REQ-017 On rst_n=0, at any time and including mid-fetch or mid-reply, state SHALL become IDLE and the following SHALL be 0 asynchronously: data_out, valid_out, cmd_out, amm_read, amm_address, operand buffer, counters.
REQ-018 The first header SHALL be accepted on the first rising clk edge with rst_n=1.

Configuration
REQ-019 Macro ALU_ENGINE_ERR_EN defined:
- a non-OKAY amm_response SHALL set the error bit;
- remaining fetches SHALL be skipped and the reply is the error reply.
Undefined:
- amm_response SHALL be ignored and amm_readdata used as-is;
- only REQ-012 N/opcode errors SHALL be reported.

Verification
REQ-020 Defaults, hdr 0x0002, ops 0x0005, 0x0003 -> hdr 0x0002, result 0x0008.
REQ-021 Hdr 0x7002, op 0x8010 (reg 0x10=0xFF, waitrequest 3 cycles), op 0x0002 -> amm_address 0x10 held 4 cycles, result 0x01FE.
REQ-022 Hdr 0x6001, op 0x0000 -> result 0xFFFF, error bit 0.
REQ-023 Hdr 0x0000 -> hdr 0x0800, data 0xFFFF after one operand.
REQ-024 ALU_ENGINE_ERR_EN defined, reg op with amm_response=10 -> hdr error bit 1, data 0xFFFF; undefined -> normal sum.
REQ-025 Hdr 0x0003, one op, new hdr 0x1002, ops 0x000F, 0x0006 -> single reply, result 0x0006; rst_n pulse mid-FETCH -> amm_read=0 and no reply.

Source files
------------

// File: rtl/alu_engine.sv
// -----------------------------------------------------------------------------
// alu_engine
//
// Purpose:
//   Command-driven ALU. A header word selects an opcode and an operand count.
//   The operand words that follow are either immediates or register-file
//   addresses. Register operands are fetched one at a time over a simple
//   read-only memory-mapped master port. The selected operation is then applied
//   to all operands. A two-word reply (header word, then result word) goes out.
//
// Ports:
//   clk              clock, single domain
//   rst_n            asynchronous active-low reset
//   data_in          command / operand word (BUS_W)
//   valid_in         data_in qualifier
//   cmd_in           1 = header word, 0 = operand word
//   data_out         reply word (BUS_W)
//   valid_out        data_out qualifier
//   cmd_out          1 = reply header, 0 = result word
//   amm_read         register-file read request
//   amm_address      register-file read address (AMM_ADDR_W)
//   amm_readdata     register-file read data (AMM_DATA_W)
//   amm_waitrequest  slave stall
//   amm_response     read response, 2'b00 = OKAY
//
// Configuration:
//   ALU_ENGINE_ERR_EN  when defined, a non-OKAY read response flags the command
//                      as erroneous and skips the remaining fetches. When not
//                      defined, amm_response is ignored.
// -----------------------------------------------------------------------------
module alu_engine #(
  parameter int BUS_W      = 16,
  parameter int AMM_ADDR_W = 8,
  parameter int AMM_DATA_W = 8,
  parameter int MAX_OPS    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BUS_W-1:0]      data_in,
  input  logic                  valid_in,
  input  logic                  cmd_in,
  output logic [BUS_W-1:0]      data_out,
  output logic                  valid_out,
  output logic                  cmd_out,
  output logic                  amm_read,
  output logic [AMM_ADDR_W-1:0] amm_address,
  input  logic [AMM_DATA_W-1:0] amm_readdata,
  input  logic                  amm_waitrequest,
  input  logic [1:0]            amm_response
);

  localparam int IDX_W = (MAX_OPS > 1) ? $clog2(MAX_OPS) : 1;
  localparam logic [3:0] MAX_N = 4'(MAX_OPS);
  localparam logic [BUS_W-1:0] ONE_W = {{(BUS_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    FETCH,
    EXEC,
    REPLY_HDR,
    REPLY_DATA
  } state_t;

  state_t state_reg;

  logic [3:0]            opcode_reg;
  logic [3:0]            n_raw_reg;     // N as received, echoed in the reply
  logic [3:0]            n_eff_reg;     // operand count actually collected
  logic [3:0]            op_cnt_reg;
  logic [IDX_W-1:0]      fetch_idx_reg;
  logic                  err_reg;
  logic [BUS_W-1:0]      result_reg;

  // Operand buffer. A set pending flag marks a register operand whose value
  // has not been fetched yet. The fetch overwrites op_val and clears the flag.
  logic [AMM_DATA_W-1:0] op_val_reg  [MAX_OPS];
  logic [AMM_ADDR_W-1:0] op_addr_reg [MAX_OPS];
  logic [MAX_OPS-1:0]    op_pending_reg;

  // ---------------------------------------------------------------------------
  // Header decode
  // ---------------------------------------------------------------------------
  logic [3:0] hdr_opcode;
  logic [3:0] hdr_n;
  logic [3:0] hdr_n_eff;
  logic       hdr_unary;
  logic       hdr_err;

  assign hdr_opcode = data_in[BUS_W-1 -: 4];
  assign hdr_n      = data_in[3:0];
  assign hdr_unary  = (hdr_opcode == 4'd4) || (hdr_opcode == 4'd5) ||
                      (hdr_opcode == 4'd6);
  assign hdr_err    = (hdr_n == 4'd0) || (hdr_n > MAX_N) || hdr_opcode[3] ||
                      (hdr_unary && (hdr_n != 4'd1));
  // A bad N still has to be collected somehow: treat 0 as 1 and clip
  // oversized counts, so that the stream stays in step with the sender.
  assign hdr_n_eff  = (hdr_n == 4'd0)  ? 4'd1 :
                      (hdr_n > MAX_N) ? MAX_N : hdr_n;

  // ---------------------------------------------------------------------------
  // Operand decode
  // ---------------------------------------------------------------------------
  logic                  opnd_is_addr;
  logic [AMM_DATA_W-1:0] opnd_imm;
  logic [AMM_ADDR_W-1:0] opnd_addr;
  logic [IDX_W-1:0]      wr_idx;

  assign opnd_is_addr = data_in[BUS_W-1];
  assign opnd_imm     = data_in[AMM_DATA_W-1:0];
  assign opnd_addr    = data_in[AMM_ADDR_W-1:0];
  assign wr_idx       = op_cnt_reg[IDX_W-1:0];

  // Only some bit fields of data_in carry meaning. amm_response is unused
  // unless the error option is built in.
  logic unused_bits;
  assign unused_bits = ^{data_in, amm_response};

  // ---------------------------------------------------------------------------
  // Zero-extended operand view
  // ---------------------------------------------------------------------------
  logic [BUS_W-1:0] op_ext [MAX_OPS];

  generate
    for (genvar gi = 0; gi < MAX_OPS; gi++) begin : g_ext
      assign op_ext[gi] = {{(BUS_W-AMM_DATA_W){1'b0}}, op_val_reg[gi]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Lowest-index register operand that is still unresolved. Fetches therefore
  // go out in operand order, and immediates cost no fetch cycles.
  // ---------------------------------------------------------------------------
  logic             pend_found;
  logic [IDX_W-1:0] pend_idx;

  always_comb begin
    pend_found = 1'b0;
    pend_idx   = '0;
    for (int i = MAX_OPS - 1; i >= 0; i--) begin
      if ((i < int'(n_eff_reg)) && op_pending_reg[i]) begin
        pend_found = 1'b1;
        pend_idx   = IDX_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic [BUS_W-1:0] alu_acc;
  logic [BUS_W-1:0] alu_result;

  always_comb begin
    alu_acc = '0;
    case (opcode_reg)
      4'd0: begin
        for (int i = 0; i < MAX_OPS; i++)
          if (i < int'(n_eff_reg)) alu_acc = alu_acc + op_ext[i];
      end
      4'd1: begin
        alu_acc = '1;
        for (int i = 0; i < MAX_OPS; i++)
          if (i < int'(n_eff_reg)) alu_acc = alu_acc & op_ext[i];
      end
      4'd2: begin
        for (int i = 0; i < MAX_OPS; i++)
          if (i < int'(n_eff_reg)) alu_acc = alu_acc | op_ext[i];
      end
      4'd3: begin
        for (int i = 0; i < MAX_OPS; i++)
          if (i < int'(n_eff_reg)) alu_acc = alu_acc ^ op_ext[i];
      end
      4'd4: alu_acc = ~op_ext[0];
      4'd5: alu_acc = op_ext[0] + ONE_W;
      4'd6: alu_acc = op_ext[0] - ONE_W;
      4'd7: begin
        alu_acc = ONE_W;
        for (int i = 0; i < MAX_OPS; i++)
          if (i < int'(n_eff_reg)) alu_acc = alu_acc * op_ext[i];
      end
      default: alu_acc = '0;
    endcase
  end

  assign alu_result = err_reg ? '1 : alu_acc;

  // Reply header: {opcode, error, zeros, N}
  logic [BUS_W-1:0] hdr_word;

  always_comb begin
    hdr_word              = '0;
    hdr_word[BUS_W-1 -: 4] = opcode_reg;
    hdr_word[BUS_W-5]      = err_reg;
    hdr_word[3:0]          = n_raw_reg;
  end

  // ---------------------------------------------------------------------------
  // Control FSM. All outputs are registered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      opcode_reg     <= '0;
      n_raw_reg      <= '0;
      n_eff_reg      <= '0;
      op_cnt_reg     <= '0;
      fetch_idx_reg  <= '0;
      err_reg        <= 1'b0;
      result_reg     <= '0;
      op_pending_reg <= '0;
      for (int i = 0; i < MAX_OPS; i++) begin
        op_val_reg[i]  <= '0;
        op_addr_reg[i] <= '0;
      end
      data_out       <= '0;
      valid_out      <= 1'b0;
      cmd_out        <= 1'b0;
      amm_read       <= 1'b0;
      amm_address    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_in && cmd_in) begin
            opcode_reg <= hdr_opcode;
            n_raw_reg  <= hdr_n;
            n_eff_reg  <= hdr_n_eff;
            err_reg    <= hdr_err;
            op_cnt_reg <= '0;
            state_reg  <= COLLECT;
          end
        end

        COLLECT: begin
          if (valid_in && cmd_in) begin
            // A new header drops the partial command and starts over.
            opcode_reg <= hdr_opcode;
            n_raw_reg  <= hdr_n;
            n_eff_reg  <= hdr_n_eff;
            err_reg    <= hdr_err;
            op_cnt_reg <= '0;
          end else if (valid_in) begin
            op_pending_reg[wr_idx] <= opnd_is_addr;
            op_addr_reg[wr_idx]    <= opnd_is_addr ? opnd_addr : '0;
            op_val_reg[wr_idx]     <= opnd_is_addr ? '0 : opnd_imm;
            op_cnt_reg             <= op_cnt_reg + 4'd1;
            if (op_cnt_reg + 4'd1 == n_eff_reg) begin
              state_reg <= FETCH;
            end
          end
        end

        FETCH: begin
          if (amm_read) begin
            if (!amm_waitrequest) begin
              op_val_reg[fetch_idx_reg]     <= amm_readdata;
              op_pending_reg[fetch_idx_reg] <= 1'b0;
              // Dropping the request here gives the required idle cycle
              // between consecutive reads.
              amm_read                      <= 1'b0;
`ifdef ALU_ENGINE_ERR_EN
              if (amm_response != 2'b00) begin
                err_reg   <= 1'b1;
                state_reg <= EXEC;
              end
`endif
            end
          end else if (pend_found) begin
            amm_read      <= 1'b1;
            amm_address   <= op_addr_reg[pend_idx];
            fetch_idx_reg <= pend_idx;
          end else begin
            state_reg <= EXEC;
          end
        end

        EXEC: begin
          result_reg <= alu_result;
          data_out   <= hdr_word;
          valid_out  <= 1'b1;
          cmd_out    <= 1'b1;
          state_reg  <= REPLY_HDR;
        end

        REPLY_HDR: begin
          data_out  <= result_reg;
          cmd_out   <= 1'b0;
          state_reg <= REPLY_DATA;
        end

        REPLY_DATA: begin
          data_out   <= '0;
          valid_out  <= 1'b0;
          cmd_out    <= 1'b0;
          op_cnt_reg <= '0;
          state_reg  <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_engine.sv
// -----------------------------------------------------------------------------
// tb_alu_engine
//
// Purpose:
//   Directed, self-checking bench for alu_engine with default parameters.
//   Contains a register-file slave model with programmable wait states and
//   response code.
//
// Ports:
//   none (top-level bench)
// -----------------------------------------------------------------------------
module tb_alu_engine;

  localparam int BUS_W      = 16;
  localparam int AMM_ADDR_W = 8;
  localparam int AMM_DATA_W = 8;
  localparam int MAX_OPS    = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [BUS_W-1:0]      data_in;
  logic                  valid_in;
  logic                  cmd_in;
  logic [BUS_W-1:0]      data_out;
  logic                  valid_out;
  logic                  cmd_out;
  logic                  amm_read;
  logic [AMM_ADDR_W-1:0] amm_address;
  logic [AMM_DATA_W-1:0] amm_readdata;
  logic                  amm_waitrequest;
  logic [1:0]            amm_response;

  always #5 clk = ~clk;

  alu_engine #(
    .BUS_W(BUS_W), .AMM_ADDR_W(AMM_ADDR_W),
    .AMM_DATA_W(AMM_DATA_W), .MAX_OPS(MAX_OPS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in(data_in), .valid_in(valid_in), .cmd_in(cmd_in),
    .data_out(data_out), .valid_out(valid_out), .cmd_out(cmd_out),
    .amm_read(amm_read), .amm_address(amm_address),
    .amm_readdata(amm_readdata), .amm_waitrequest(amm_waitrequest),
    .amm_response(amm_response)
  );

  // ---------------- register-file slave ----------------
  logic [7:0] mem [256];
  int         wait_cfg = 0;
  logic [1:0] resp_cfg = 2'b00;
  int         wcnt = 0;

  always @(posedge clk) begin
    if (amm_read && amm_waitrequest) wcnt <= wcnt + 1;
    else                             wcnt <= 0;
  end

  assign amm_waitrequest = amm_read && (wcnt < wait_cfg);
  assign amm_readdata    = mem[amm_address];
  assign amm_response    = (amm_read && !amm_waitrequest) ? resp_cfg : 2'b00;

  // ---------------- bus monitor ----------------
  int         a10_cycles = 0;   // cycles with amm_read=1 at address 0x10
  int         gap_viol   = 0;   // read re-asserted right after an accept
  int         hold_viol  = 0;   // address moved while stalled
  int         reply_hdrs = 0;
  logic       prev_accept = 1'b0;
  logic       prev_wait   = 1'b0;
  logic [7:0] prev_addr   = 8'h00;

  always @(negedge clk) begin
    if (amm_read && amm_address == 8'h10) a10_cycles++;
    if (prev_accept && amm_read) gap_viol++;
    if (prev_wait && amm_address != prev_addr) hold_viol++;
    prev_accept = amm_read && !amm_waitrequest;
    prev_wait   = amm_read && amm_waitrequest;
    prev_addr   = amm_address;
    if (valid_out && cmd_out) reply_hdrs++;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] w, input logic c);
    @(negedge clk);
    data_in  = w;
    cmd_in   = c;
    valid_in = 1'b1;
  endtask

  task automatic idle_bus();
    @(negedge clk);
    data_in  = '0;
    cmd_in   = 1'b0;
    valid_in = 1'b0;
  endtask

  // Called at the first falling edge after the last operand was accepted.
  task automatic wait_reply(input string name, input logic [15:0] eh,
                            input logic [15:0] ed, output int lat);
    logic [15:0] got_hdr;
    lat = 1;
    while (!(valid_out && cmd_out) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!(valid_out && cmd_out)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s reply timeout: got no header, expected 0x%0h", name, eh);
    end else begin
      got_hdr = data_out;
      check({name, " hdr"}, {14'd0, valid_out, cmd_out, data_out}, {14'd0, 2'b11, eh});
      @(negedge clk);
      lat++;
      check({name, " data"}, {14'd0, valid_out, cmd_out, data_out}, {14'd0, 2'b10, ed});
      $display("txn %-10s hdr 0x%04h data 0x%04h latency %0d", name, got_hdr, data_out, lat);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string            name;
    logic [15:0]      hdr;
    int               n;
    logic [7:0][15:0] ops;
    int               wt;
    logic [1:0]       resp;
    logic [15:0]      exp_hdr;
    logic [15:0]      exp_data;
    int               exp_lat;   // 0 = not checked
    int               exp_a10;   // -1 = not checked
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string nm, input logic [15:0] h, input int n,
                         input logic [7:0][15:0] o, input int wt, input logic [1:0] rs,
                         input logic [15:0] eh, input logic [15:0] ed,
                         input int el, input int ea);
    vec_t v;
    v.name = nm; v.hdr = h; v.n = n; v.ops = o; v.wt = wt; v.resp = rs;
    v.exp_hdr = eh; v.exp_data = ed; v.exp_lat = el; v.exp_a10 = ea;
    vq.push_back(v);
  endtask

  function automatic logic [7:0][15:0] ops8(input logic [15:0] a, b = 16'h0, c = 16'h0,
                                             d = 16'h0, e = 16'h0, f = 16'h0,
                                             g = 16'h0, h = 16'h0);
    logic [7:0][15:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    r[4] = e; r[5] = f; r[6] = g; r[7] = h;
    return r;
  endfunction

  initial begin
    int lat;
    int a0, r0;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'hFF;
    mem[8'h20] = 8'h0A;
    mem[8'h40] = 8'h07;

    add_vec("add2",   16'h0002, 2, ops8(16'h0005, 16'h0003), 0, 2'b00, 16'h0002, 16'h0008, 4, -1);
    add_vec("mulreg", 16'h7002, 2, ops8(16'h8010, 16'h0002), 3, 2'b00, 16'h7002, 16'h01FE, 0, 4);
    add_vec("dec0",   16'h6001, 1, ops8(16'h0000),           0, 2'b00, 16'h6001, 16'hFFFF, 4, -1);
    add_vec("and2",   16'h1002, 2, ops8(16'h000F, 16'h0006), 0, 2'b00, 16'h1002, 16'h0006, 0, -1);
    add_vec("or3",    16'h2003, 3, ops8(16'h0011, 16'h0022, 16'h0044), 0, 2'b00, 16'h2003, 16'h0077, 0, -1);
    add_vec("xor2",   16'h3002, 2, ops8(16'h00FF, 16'h000F), 0, 2'b00, 16'h3002, 16'h00F0, 0, -1);
    add_vec("not",    16'h4001, 1, ops8(16'h0055),           0, 2'b00, 16'h4001, 16'hFFAA, 0, -1);
    add_vec("inc",    16'h5001, 1, ops8(16'h00FF),           0, 2'b00, 16'h5001, 16'h0100, 0, -1);
    add_vec("n0",     16'h0000, 1, ops8(16'h0005),           0, 2'b00, 16'h0800, 16'hFFFF, 0, -1);
    add_vec("unaryn2",16'h4002, 2, ops8(16'h0001, 16'h0002), 0, 2'b00, 16'h4802, 16'hFFFF, 0, -1);
    add_vec("illegal",16'h8001, 1, ops8(16'h0001),           0, 2'b00, 16'h8801, 16'hFFFF, 0, -1);
    add_vec("nbig",   16'h000F, 8, ops8(16'h0001, 16'h0001, 16'h0001, 16'h0001,
                                        16'h0001, 16'h0001, 16'h0001, 16'h0001),
            0, 2'b00, 16'h080F, 16'hFFFF, 0, -1);
    add_vec("add2reg",16'h0003, 3, ops8(16'h8020, 16'h8010, 16'h0001), 1, 2'b00, 16'h0003, 16'h010A, 0, 2);
    add_vec("mulwrap",16'h7003, 3, ops8(16'h00FF, 16'h00FF, 16'h0002), 0, 2'b00, 16'h7003, 16'hFC02, 0, -1);
`ifdef ALU_ENGINE_ERR_EN
    add_vec("resperr",16'h0002, 2, ops8(16'h8040, 16'h0003), 0, 2'b10, 16'h0802, 16'hFFFF, 0, -1);
`else
    add_vec("resperr",16'h0002, 2, ops8(16'h8040, 16'h0003), 0, 2'b10, 16'h0002, 16'h000A, 0, -1);
`endif

    // ---------------- reset state ----------------
    rst_n    = 1'b0;
    data_in  = '0;
    valid_in = 1'b0;
    cmd_in   = 1'b0;
    #1;
    check("reset outputs", {5'd0, valid_out, cmd_out, amm_read, amm_address, data_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    foreach (vq[k]) begin
      wait_cfg = vq[k].wt;
      resp_cfg = vq[k].resp;
      a0 = a10_cycles;
      send(vq[k].hdr, 1'b1);
      for (int j = 0; j < vq[k].n; j++) send(vq[k].ops[j], 1'b0);
      idle_bus();
      wait_reply(vq[k].name, vq[k].exp_hdr, vq[k].exp_data, lat);
      if (vq[k].exp_lat != 0) check({vq[k].name, " latency"}, lat, vq[k].exp_lat);
      if (vq[k].exp_a10 >= 0) check({vq[k].name, " addr hold"}, a10_cycles - a0, vq[k].exp_a10);
      repeat (2) @(negedge clk);
    end
    resp_cfg = 2'b00;
    check("read gap", gap_viol, 0);
    check("addr stable", hold_viol, 0);

    // ---------------- stray operand in IDLE, restart in COLLECT ----------------
    wait_cfg = 0;
    r0 = reply_hdrs;
    send(16'h0009, 1'b0);
    send(16'h0003, 1'b1);
    send(16'h0001, 1'b0);
    send(16'h1002, 1'b1);
    send(16'h000F, 1'b0);
    send(16'h0006, 1'b0);
    idle_bus();
    wait_reply("restart", 16'h1002, 16'h0006, lat);
    repeat (10) @(negedge clk);
    check("restart reply count", reply_hdrs - r0, 1);

    // ---------------- reset during FETCH ----------------
    wait_cfg = 20;
    send(16'h0001, 1'b1);
    send(16'h8010, 1'b0);
    idle_bus();
    for (int t = 0; t < 10 && !amm_read; t++) @(negedge clk);
    check("fetch started", {31'd0, amm_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset", {5'd0, valid_out, cmd_out, amm_read, amm_address, data_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    r0 = reply_hdrs;
    repeat (12) @(negedge clk);
    check("no reply after reset", reply_hdrs - r0, 0);
    check("read idle after reset", {31'd0, amm_read}, 32'd0);

    // ---------------- normal command after reset ----------------
    wait_cfg = 0;
    send(16'h0002, 1'b1);
    send(16'h0005, 1'b0);
    send(16'h0003, 1'b0);
    idle_bus();
    wait_reply("postreset", 16'h0002, 16'h0008, lat);
    check("postreset latency", lat, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
